mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data-side grants tolerated while the instruction side waits.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_req, input, mem_bus_req_t, request from the instruction cache.
REQ-005 SHALL have port i_resp, output, mem_bus_resp_t, response to the instruction cache.
REQ-006 SHALL have port d_req, input, mem_bus_req_t, request from the data cache.
REQ-007 SHALL have port d_resp, output, mem_bus_resp_t, response to the data cache.
REQ-008 SHALL have port mem_req, output, mem_bus_req_t, request to the shared memory bus.
REQ-009 SHALL have port mem_resp, input, mem_bus_resp_t, response from the shared memory bus.
REQ-010 SHALL have port grant, output, 2, one-hot owner status: bit0 = instruction, bit1 = data, 00 = idle.

Function
REQ-011 SHALL implement FSM states IDLE, GNT_I and GNT_D; grant SHALL equal 01 in GNT_I, 10 in GNT_D and 00 in IDLE.
REQ-012 SHALL, in IDLE, move to GNT_D if d_req.valid, else to GNT_I if i_req.valid, else stay in IDLE; the one-cycle arbitration latency is intentional.
REQ-013 SHALL drive mem_req = d_req in GNT_D, mem_req = i_req in GNT_I, and mem_req = all-zero in IDLE, combinationally from the registered state.
REQ-014 SHALL route mem_resp to the owner's response port only; the non-owner's response SHALL be all-zero, so its ready = 0.
REQ-015 SHALL, in a GNT state, return to IDLE on the cycle after mem_resp.ready = 1; there is one bubble cycle between back-to-back transactions.
REQ-016 SHALL, if the owner deasserts valid before mem_resp.ready, return to IDLE the next cycle and drop mem_req.valid; this abandoned transfer is not retried.
REQ-017 SHALL treat a simultaneous mem_resp.ready and owner valid drop as completion.
REQ-018 SHALL never grant both requesters in the same cycle; a non-owner's valid is ignored until IDLE.
REQ-019 SHALL never change ownership mid-transaction, including a stall of any length.

Reset
REQ-020 SHALL, while reset = 1 at a clock edge, enter IDLE and clear the starvation counter.
REQ-021 SHALL, after reset, produce grant = 00, mem_req all-zero, and i_resp/d_resp all-zero.
REQ-022 SHALL, on reset mid-transaction, drop mem_req.valid on the cycle after the reset edge without waiting for mem_resp.ready.

Configuration
REQ-023 SHALL, with ARB_STARVE_GUARD_EN defined, increment a saturating counter (width $clog2(STARVE_LIMIT+1)) on each IDLE->GNT_D decision taken while i_req.valid = 1.
REQ-024 SHALL, with ARB_STARVE_GUARD_EN defined, clear that counter on every IDLE->GNT_I decision.
REQ-025 SHALL, with ARB_STARVE_GUARD_EN defined and the counter equal to STARVE_LIMIT, make the next IDLE decision with i_req.valid = 1 go to GNT_I even if d_req.valid = 1.
REQ-026 SHALL, without ARB_STARVE_GUARD_EN, give strict data priority and contain no counter logic.

Structure
REQ-027 SHALL take mem_bus_req_t and mem_bus_resp_t from the structures package; that package SHALL also hold the FSM state enum arb_state_t.
REQ-028 SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-029 SHALL test: i_req.valid = 1 alone, addr 0x1000, memory ready after 3 cycles -> grant 01 on cycle 1, i_resp.ready on cycle 4, IDLE on cycle 5.
REQ-030 SHALL test: i_req and d_req valid in the same cycle -> GNT_D first, and d_resp is the only response with ready.
REQ-031 SHALL test: i_req stalled while d_req stays valid for 6 transactions, with ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4 -> the 5th grant is GNT_I; without the macro all 6 are GNT_D.
REQ-032 SHALL test: owner drops valid on the 2nd stall cycle -> mem_req.valid = 0 and grant = 00 the next cycle.
REQ-033 SHALL test: reset asserted in GNT_D with mem_resp.ready = 0 -> mem_req all-zero and grant = 00 after the edge.
REQ-034 SHALL test: assertion grant != 11 held for every cycle, and every ready on i_resp or d_resp matches the current grant bit.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: request/response
// payloads and the arbiter FSM state encoding.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   // Request from a master toward memory
   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mem_bus_req_t;

   // Response from memory toward a master
   typedef struct packed {
      logic              ready;
      logic [DATA_W-1:0] rdata;
   } mem_bus_resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   // One-hot owner status for a given state (bit0 = instruction, bit1 = data)
   function automatic logic [1:0] grant_of(input arb_state_t s);
      case (s)
         GNT_I:   grant_of = 2'b01;
         GNT_D:   grant_of = 2'b10;
         default: grant_of = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between an instruction cache and a
// data cache. Data side has priority; ownership is held until memory
// signals ready or the owner withdraws its request.
//
// Ports:
//   clock, reset     - single clock, synchronous active-high reset
//   i_req / i_resp   - instruction cache request in / response out
//   d_req / d_resp   - data cache request in / response out
//   mem_req/mem_resp - shared memory bus request out / response in
//   grant            - one-hot owner status (01 = instr, 10 = data, 00 = idle)
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the starvation
// guard, which forces an instruction grant after STARVE_LIMIT consecutive
// data grants taken while the instruction side was waiting.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  mem_bus_req_t  i_req,
   output mem_bus_resp_t i_resp,
   input  mem_bus_req_t  d_req,
   output mem_bus_resp_t d_resp,
   output mem_bus_req_t  mem_req,
   input  mem_bus_resp_t mem_resp,
   output logic [1:0]    grant
);

   // The guard counter needs a limit of at least one to be meaningful
   if (STARVE_LIMIT == 0) begin : g_bad_limit
      $error("mem_bus_arbiter: STARVE_LIMIT must be at least 1");
   end

   arb_state_t state;
   arb_state_t state_next;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_next;
`endif

   // State (and guard counter) register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
         starve_cnt <= '0;
`endif
      end else begin
         state <= state_next;
`ifdef ARB_STARVE_GUARD_EN
         starve_cnt <= starve_cnt_next;
`endif
      end
   end

   // Next-state: arbitrate only from IDLE, release on ready or valid drop
   always_comb begin
      state_next = state;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_next = starve_cnt;
`endif
      case (state)
         IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
            if (i_req.valid && (starve_cnt == CNT_MAX)) begin
               // Instruction side has waited long enough; override data priority
               state_next      = GNT_I;
               starve_cnt_next = '0;
            end else if (d_req.valid) begin
               state_next = GNT_D;
               if (i_req.valid && (starve_cnt < CNT_MAX)) begin
                  starve_cnt_next = starve_cnt + CNT_W'(1);
               end
            end else if (i_req.valid) begin
               state_next      = GNT_I;
               starve_cnt_next = '0;
            end
`else
            if (d_req.valid) begin
               state_next = GNT_D;
            end else if (i_req.valid) begin
               state_next = GNT_I;
            end
`endif
         end
         GNT_I: begin
            if (mem_resp.ready || !i_req.valid) begin
               state_next = IDLE;
            end
         end
         GNT_D: begin
            if (mem_resp.ready || !d_req.valid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bus routing decoded from the registered state; non-owner sees zeros
   always_comb begin
      mem_req = '0;
      i_resp  = '0;
      d_resp  = '0;
      grant   = grant_of(state);
      case (state)
         GNT_I: begin
            mem_req = i_req;
            i_resp  = mem_resp;
         end
         GNT_D: begin
            mem_req = d_req;
            d_resp  = mem_resp;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. Inputs are driven just
// after the falling edge and outputs sampled 1 time unit later. Expected
// values for the starvation scenario depend on ARB_STARVE_GUARD_EN.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic          clock;
   logic          reset;
   mem_bus_req_t  i_req;
   mem_bus_resp_t i_resp;
   mem_bus_req_t  d_req;
   mem_bus_resp_t d_resp;
   mem_bus_req_t  mem_req;
   mem_bus_resp_t mem_resp;
   logic [1:0]    grant;

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;

   mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .i_req    (i_req),
      .i_resp   (i_resp),
      .d_req    (d_req),
      .d_resp   (d_resp),
      .mem_req  (mem_req),
      .mem_resp (mem_resp),
      .grant    (grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Every cycle: never both granted, and any response ready belongs to the owner
   always @(negedge clock) begin
      if (mon_en) begin
         #2;
         check("no_dual_grant", 128'(grant == 2'b11), 128'h0);
         check("i_ready_owner", 128'(i_resp.ready & ~grant[0]), 128'h0);
         check("d_ready_owner", 128'(d_resp.ready & ~grant[1]), 128'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [1:0] exp_g [6];
   mem_bus_req_t ireq_v;
   mem_bus_req_t dreq_v;
   int n;

   initial begin
`ifdef ARB_STARVE_GUARD_EN
      exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10;
      exp_g[3] = 2'b10; exp_g[4] = 2'b01; exp_g[5] = 2'b10;
`else
      for (int k = 0; k < 6; k++) exp_g[k] = 2'b10;
`endif
      reset    = 1'b1;
      i_req    = '0;
      d_req    = '0;
      mem_resp = '{ready: 1'b1, rdata: 32'hdead_beef};
      tick();
      tick();
      #1;
      // Reset state: even with memory asserting ready, nothing is routed
      check("rst_grant",  128'(grant),   128'h0);
      check("rst_memreq", 128'(mem_req), 128'h0);
      check("rst_iresp",  128'(i_resp),  128'h0);
      check("rst_dresp",  128'(d_resp),  128'h0);
      reset    = 1'b0;
      mem_resp = '0;
      mon_en   = 1'b1;
      tick();

      // Single instruction fetch at 0x1000, memory ready on cycle 4
      ireq_v = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_1000, wdata: 32'h0, be: 4'hf};
      i_req  = ireq_v;                      // cycle 0
      tick(); #1;                           // cycle 1
      check("i_grant_c1",  128'(grant),        128'h1);
      check("i_memreq_c1", 128'(mem_req),      128'(ireq_v));
      check("i_ready_c1",  128'(i_resp.ready), 128'h0);
      tick(); #1;                           // cycle 2
      check("i_grant_c2", 128'(grant), 128'h1);
      tick();                               // cycle 4 follows cycle 3
      tick();
      mem_resp = '{ready: 1'b1, rdata: 32'h0000_1234};
      #1;
      check("i_resp_c4",  128'(i_resp), 128'(mem_resp));
      check("d_resp_c4",  128'(d_resp), 128'h0);
      check("i_grant_c4", 128'(grant),  128'h1);
      tick(); #1;                           // cycle 5
      check("i_idle_c5",   128'(grant),   128'h0);
      check("idle_memreq", 128'(mem_req), 128'h0);
      i_req    = '0;
      mem_resp = '0;
      tick();

      // Simultaneous requests: data wins, instruction is served afterwards
      ireq_v = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_2000, wdata: 32'h0, be: 4'hf};
      dreq_v = '{valid: 1'b1, we: 1'b1, addr: 32'h0000_3000, wdata: 32'hcafe_f00d, be: 4'h3};
      i_req  = ireq_v;
      d_req  = dreq_v;
      tick(); #1;
      check("both_grant_d", 128'(grant),   128'h2);
      check("both_memreq",  128'(mem_req), 128'(dreq_v));
      mem_resp = '{ready: 1'b1, rdata: 32'h0000_0055};
      #1;
      check("both_d_ready", 128'(d_resp.ready), 128'h1);
      check("both_i_zero",  128'(i_resp),       128'h0);
      tick(); #1;
      check("both_bubble", 128'(grant), 128'h0);
      d_req    = '0;
      mem_resp = '0;
      tick(); #1;
      check("both_then_i", 128'(grant), 128'h1);
      mem_resp = '{ready: 1'b1, rdata: 32'h0000_0066};
      tick(); #1;
      check("both_i_done", 128'(grant), 128'h0);
      i_req    = '0;
      mem_resp = '0;
      tick();

      // Instruction side waits while data keeps requesting for 6 transactions
      i_req = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_4000, wdata: 32'h0, be: 4'hf};
      d_req = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_4800, wdata: 32'h0, be: 4'hf};
      for (int k = 0; k < 6; k++) begin
         n = 0;
         do begin
            tick(); #1;
            n++;
         end while (grant == 2'b00 && n < 4);
         check($sformatf("starve_grant_%0d", k), 128'(grant), 128'(exp_g[k]));
         mem_resp = '{ready: 1'b1, rdata: 32'h0};
         tick(); #1;
         check($sformatf("starve_release_%0d", k), 128'(grant), 128'h0);
         mem_resp = '0;
      end
      i_req = '0;
      d_req = '0;
      tick();
      tick();

      // Owner drops valid on the 2nd stall cycle while the other side waits
      dreq_v = '{valid: 1'b1, we: 1'b1, addr: 32'h0000_5000, wdata: 32'h1111_2222, be: 4'hf};
      d_req  = dreq_v;
      tick(); #1;                           // granted, stall cycle 1
      check("drop_grant", 128'(grant), 128'h2);
      i_req = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_6000, wdata: 32'h0, be: 4'hf};
      tick(); #1;                           // stall cycle 2: ownership held
      check("drop_hold",  128'(grant),  128'h2);
      check("drop_izero", 128'(i_resp), 128'h0);
      d_req = '0;
      tick(); #1;
      check("drop_grant_idle", 128'(grant),         128'h0);
      check("drop_memvalid",   128'(mem_req.valid), 128'h0);
      tick(); #1;
      check("drop_then_i", 128'(grant), 128'h1);
      // Ready coinciding with a valid drop still completes normally
      mem_resp = '{ready: 1'b1, rdata: 32'h0000_0077};
      i_req    = '0;
      tick(); #1;
      check("simul_drop_idle", 128'(grant), 128'h0);
      mem_resp = '0;
      tick();

      // Reset mid-transaction with memory stalled
      d_req = '{valid: 1'b1, we: 1'b0, addr: 32'h0000_7000, wdata: 32'h0, be: 4'hf};
      tick(); #1;
      check("rst_mid_grant", 128'(grant), 128'h2);
      reset = 1'b1;
      tick(); #1;
      check("rst_mid_memreq", 128'(mem_req), 128'h0);
      check("rst_mid_gidle",  128'(grant),   128'h0);
      check("rst_mid_dresp",  128'(d_resp),  128'h0);
      reset = 1'b0;
      d_req = '0;
      tick(); #1;
      check("post_rst_idle", 128'(grant), 128'h0);

      mon_en = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
